// File: rtl/hemaia_mem_superbank_arbiter.sv
// Super-bank arbiter: round-robin among wide requestors, bounded narrow lock-out,
// and a tagged delay line that routes SRAM read data back to its requestor.
module hemaia_mem_superbank_arbiter #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned NumWideInp      = 2,
  parameter int unsigned MemAddrWidth    = 10,
  parameter int unsigned MaxWideBurst    = 4,
  parameter int unsigned MemLatency      = 1,
  localparam int unsigned BanksPerSB      = WideDataWidth / NarrowDataWidth,
  localparam int unsigned NarrowStrbWidth = NarrowDataWidth / 8,
  localparam int unsigned WideStrbWidth   = WideDataWidth / 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumWideInp-1:0]                   wide_valid_i,
  output logic [NumWideInp-1:0]                   wide_ready_o,
  input  logic [NumWideInp*MemAddrWidth-1:0]      wide_addr_i,
  input  logic [NumWideInp-1:0]                   wide_write_i,
  input  logic [NumWideInp*WideDataWidth-1:0]     wide_wdata_i,
  input  logic [NumWideInp*WideStrbWidth-1:0]     wide_strb_i,
  output logic [NumWideInp-1:0]                   wide_rsp_valid_o,
  output logic [WideDataWidth-1:0]                wide_rdata_o,
  input  logic [BanksPerSB-1:0]                   narrow_valid_i,
  output logic [BanksPerSB-1:0]                   narrow_ready_o,
  input  logic [BanksPerSB*MemAddrWidth-1:0]      narrow_addr_i,
  input  logic [BanksPerSB-1:0]                   narrow_write_i,
  input  logic [BanksPerSB*NarrowDataWidth-1:0]   narrow_wdata_i,
  input  logic [BanksPerSB*NarrowStrbWidth-1:0]   narrow_strb_i,
  output logic [BanksPerSB-1:0]                   narrow_rsp_valid_o,
  output logic [BanksPerSB*NarrowDataWidth-1:0]   narrow_rdata_o,
  output logic [BanksPerSB-1:0]                   mem_cs_o,
  output logic [BanksPerSB-1:0]                   mem_wen_o,
  output logic [BanksPerSB*MemAddrWidth-1:0]      mem_add_o,
  output logic [BanksPerSB*NarrowStrbWidth-1:0]   mem_be_o,
  output logic [BanksPerSB*NarrowDataWidth-1:0]   mem_wdata_o,
  input  logic [BanksPerSB*NarrowDataWidth-1:0]   mem_rdata_i
);

  localparam int unsigned IdxWidth = (NumWideInp > 1) ? $clog2(NumWideInp) : 1;
  localparam int unsigned CntWidth = (MaxWideBurst > 0) ? $clog2(MaxWideBurst + 1) : 1;

  typedef struct packed {
    logic                  valid;
    logic                  is_wide;
    logic [IdxWidth-1:0]   idx;
    logic [BanksPerSB-1:0] mask;
  } rsp_entry_t;

  logic [IdxWidth-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]     burst_cnt_q, burst_cnt_d;
  rsp_entry_t              rsp_line_q [MemLatency];
  rsp_entry_t              rsp_line_d [MemLatency];
  rsp_entry_t              rsp_new, rsp_out;

  logic                    any_w, any_n, force_n, wide_mode, narrow_mode, sel_found;
  logic [IdxWidth-1:0]     sel_idx;
  logic [2*NumWideInp-1:0] rot_dbl;
  logic [BanksPerSB-1:0]   narrow_reads;

  // Mode decision and round-robin pick starting at rr_ptr
  always_comb begin
    any_w     = |wide_valid_i;
    any_n     = |narrow_valid_i;
    force_n   = (MaxWideBurst != 0) && any_n && (burst_cnt_q == CntWidth'(MaxWideBurst));
    wide_mode   = !rst_i && any_w && !force_n;
    narrow_mode = !rst_i && !wide_mode;
    rot_dbl   = {wide_valid_i, wide_valid_i} >> rr_ptr_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NumWideInp; i++) begin
      if (!sel_found && rot_dbl[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxWidth'((32'(rr_ptr_q) + 32'(i)) % NumWideInp);
      end
    end
  end

  // Handshakes and bank drive
  always_comb begin
    wide_ready_o   = '0;
    narrow_ready_o = '0;
    mem_cs_o       = '0;
    mem_wen_o      = '0;
    mem_add_o      = '0;
    mem_be_o       = '0;
    mem_wdata_o    = '0;
    if (wide_mode) begin
      wide_ready_o[sel_idx] = 1'b1;
    end else if (narrow_mode) begin
      narrow_ready_o = narrow_valid_i;
    end
    for (int unsigned j = 0; j < BanksPerSB; j++) begin
      if (wide_mode) begin
        mem_cs_o[j]  = 1'b1;
        mem_wen_o[j] = wide_write_i[sel_idx];
        mem_add_o[j*MemAddrWidth +: MemAddrWidth] =
          wide_addr_i[sel_idx*MemAddrWidth +: MemAddrWidth];
        mem_wdata_o[j*NarrowDataWidth +: NarrowDataWidth] =
          wide_wdata_i[sel_idx*WideDataWidth + j*NarrowDataWidth +: NarrowDataWidth];
        mem_be_o[j*NarrowStrbWidth +: NarrowStrbWidth] =
          wide_strb_i[sel_idx*WideStrbWidth + j*NarrowStrbWidth +: NarrowStrbWidth];
      end else if (narrow_mode) begin
        mem_cs_o[j]  = narrow_valid_i[j];
        mem_wen_o[j] = narrow_write_i[j];
        mem_add_o[j*MemAddrWidth +: MemAddrWidth] =
          narrow_addr_i[j*MemAddrWidth +: MemAddrWidth];
        mem_wdata_o[j*NarrowDataWidth +: NarrowDataWidth] =
          narrow_wdata_i[j*NarrowDataWidth +: NarrowDataWidth];
        mem_be_o[j*NarrowStrbWidth +: NarrowStrbWidth] =
          narrow_strb_i[j*NarrowStrbWidth +: NarrowStrbWidth];
      end
    end
  end

  // Next state: pointer, burst counter, response delay line
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = '0;
    narrow_reads = narrow_valid_i & ~narrow_write_i;
    rsp_new      = '0;
    if (wide_mode) begin
      rr_ptr_d = IdxWidth'((32'(sel_idx) + 32'd1) % NumWideInp);
      if (any_n) begin
        burst_cnt_d = (burst_cnt_q == CntWidth'(MaxWideBurst)) ? burst_cnt_q
                                                                 : burst_cnt_q + 1'b1;
      end
      rsp_new.valid   = !wide_write_i[sel_idx];
      rsp_new.is_wide = 1'b1;
      rsp_new.idx     = sel_idx;
    end else if (narrow_mode) begin
      rsp_new.valid = |narrow_reads;
      rsp_new.mask  = narrow_reads;
    end
    rsp_line_d[0] = rsp_new;
    for (int unsigned i = 1; i < MemLatency; i++) begin
      rsp_line_d[i] = rsp_line_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      for (int unsigned i = 0; i < MemLatency; i++) begin
        rsp_line_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      for (int unsigned i = 0; i < MemLatency; i++) begin
        rsp_line_q[i] <= rsp_line_d[i];
      end
    end
  end

  // Response decode at the delay-line output; suppressed while in reset
  always_comb begin
    rsp_out            = rsp_line_q[MemLatency-1];
    wide_rsp_valid_o   = '0;
    narrow_rsp_valid_o = '0;
    wide_rdata_o       = mem_rdata_i;
    narrow_rdata_o     = mem_rdata_i;
    if (!rst_i && rsp_out.valid) begin
      if (rsp_out.is_wide) begin
        wide_rsp_valid_o[rsp_out.idx] = 1'b1;
      end else begin
        narrow_rsp_valid_o = rsp_out.mask;
      end
    end
  end

endmodule

// File: tb/tb_hemaia_mem_superbank_arbiter.sv
// Bench for the super-bank arbiter: three configurations share one stimulus stream and
// are compared every cycle against a transaction-level model with a reference memory.
`timescale 1ns/1ps
module tb_hemaia_mem_superbank_arbiter;
  localparam int unsigned NDW = 64, WDW = 512, W = 2, AW = 10, B = 8, NInst = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [W-1:0]         wv, ww;
  logic [W*AW-1:0]      waddr;
  logic [W*WDW-1:0]     wwdata;
  logic [W*WDW/8-1:0]   wstrb;
  logic [B-1:0]         nv, nw;
  logic [B*AW-1:0]      naddr;
  logic [B*NDW-1:0]     nwdata;
  logic [B*NDW/8-1:0]   nstrb;

  logic [W-1:0]       wide_ready [NInst], wide_rsp_valid [NInst];
  logic [WDW-1:0]     wide_rdata [NInst];
  logic [B-1:0]       narrow_ready [NInst], narrow_rsp_valid [NInst], mem_cs [NInst], mem_wen [NInst];
  logic [B*NDW-1:0]   narrow_rdata [NInst], mem_wdata [NInst], mem_rdata [NInst];
  logic [B*AW-1:0]    mem_add [NInst];
  logic [B*NDW/8-1:0] mem_be [NInst];

  // Three configurations: {MaxWideBurst, MemLatency} = {4,1}, {0,3}, {2,2}
  for (genvar g = 0; g < NInst; g++) begin : g_dut
    localparam int unsigned MB = (g == 0) ? 4 : ((g == 1) ? 0 : 2);
    localparam int unsigned LT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    logic [63:0]      sram [B][1024];
    logic [B*NDW-1:0] pipe [LT];

    hemaia_mem_superbank_arbiter #(
      .NarrowDataWidth(NDW), .WideDataWidth(WDW), .NumWideInp(W),
      .MemAddrWidth(AW), .MaxWideBurst(MB), .MemLatency(LT)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .wide_valid_i(wv), .wide_ready_o(wide_ready[g]), .wide_addr_i(waddr),
      .wide_write_i(ww), .wide_wdata_i(wwdata), .wide_strb_i(wstrb),
      .wide_rsp_valid_o(wide_rsp_valid[g]), .wide_rdata_o(wide_rdata[g]),
      .narrow_valid_i(nv), .narrow_ready_o(narrow_ready[g]), .narrow_addr_i(naddr),
      .narrow_write_i(nw), .narrow_wdata_i(nwdata), .narrow_strb_i(nstrb),
      .narrow_rsp_valid_o(narrow_rsp_valid[g]), .narrow_rdata_o(narrow_rdata[g]),
      .mem_cs_o(mem_cs[g]), .mem_wen_o(mem_wen[g]), .mem_add_o(mem_add[g]),
      .mem_be_o(mem_be[g]), .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g])
    );

    assign mem_rdata[g] = pipe[LT-1];

    initial begin
      for (int j = 0; j < B; j++)
        for (int a = 0; a < 1024; a++) sram[j][a] <= '0;
      for (int l = 0; l < LT; l++) pipe[l] <= '0;
    end

    // SRAM banks with LT-cycle read latency
    always @(posedge clk) begin
      logic [B*NDW-1:0] rd;
      logic [63:0]      word;
      logic [AW-1:0]    a;
      rd = '0;
      for (int j = 0; j < B; j++) begin
        if (mem_cs[g][j]) begin
          a    = mem_add[g][j*AW +: AW];
          word = sram[j][a];
          if (mem_wen[g][j]) begin
            for (int b = 0; b < 8; b++)
              if (mem_be[g][j*8+b]) word[b*8 +: 8] = mem_wdata[g][j*64 + b*8 +: 8];
            sram[j][a] <= word;
          end else begin
            rd[j*64 +: 64] = word;
          end
        end
      end
      pipe[0] <= rd;
      for (int l = 1; l < LT; l++) pipe[l] <= pipe[l-1];
    end
  end

  // Reference model state
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;
  int          m_rr [NInst], m_cnt [NInst];
  logic [63:0] ref_mem [NInst][B][1024];
  bit          sv [NInst][8];
  int          sdue [NInst][8];
  bit          swide [NInst][8];
  int          sidx [NInst][8];
  logic [7:0]  smask [NInst][8];
  logic [511:0] sdata [NInst][8];

  function automatic int mb_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 0 : 2);
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
  endfunction

  task automatic check(input string nm, input int g, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, g, cyc, act, exp);
  endtask

  task automatic schedule(input int g, input bit is_w, input int idx, input logic [7:0] mask,
                          input logic [511:0] data);
    int s;
    s = (cyc + lat_of(g)) % 8;
    sv[g][s] = 1'b1; sdue[g][s] = cyc + lat_of(g); swide[g][s] = is_w;
    sidx[g][s] = idx; smask[g][s] = mask; sdata[g][s] = data;
  endtask

  // Expected outputs this cycle from the arbitration rules, then advance model state
  task automatic model_check(input int g);
    logic [1:0]   e_wr, e_wrv;
    logic [7:0]   e_nr, e_cs, e_wen, e_nrv, mask;
    logic [79:0]  e_add, add_mask;
    logic [511:0] e_d, d_mask, data;
    logic [63:0]  word;
    logic [9:0]   a;
    int slot, k, c, mb;
    bit any_w, any_n, force_n;
    e_wr = '0; e_wrv = '0; e_nr = '0; e_cs = '0; e_wen = '0; e_nrv = '0;
    e_add = '0; add_mask = '0; e_d = '0; d_mask = '0; data = '0; mask = '0;
    mb = mb_of(g);
    slot = cyc % 8;
    if (rst) begin
      m_rr[g] = 0; m_cnt[g] = 0;
      for (int s = 0; s < 8; s++) sv[g][s] = 1'b0;
    end else begin
      if (sv[g][slot] && sdue[g][slot] == cyc) begin
        e_d = sdata[g][slot];
        if (swide[g][slot]) begin
          e_wrv[sidx[g][slot]] = 1'b1;
        end else begin
          e_nrv = smask[g][slot];
          for (int j = 0; j < B; j++) if (e_nrv[j]) d_mask[j*64 +: 64] = '1;
        end
        sv[g][slot] = 1'b0;
      end
      any_w = |wv; any_n = |nv;
      force_n = (mb != 0) && any_n && (m_cnt[g] == mb);
      if (any_w && !force_n) begin
        k = -1;
        for (int i = 0; i < W; i++) begin
          c = (m_rr[g] + i) % W;
          if (k < 0 && wv[c]) k = c;
        end
        e_wr[k] = 1'b1; e_cs = '1; e_wen = ww[k] ? 8'hFF : 8'h00;
        a = waddr[k*AW +: AW];
        for (int j = 0; j < B; j++) e_add[j*AW +: AW] = a;
        m_rr[g] = (k + 1) % W;
        m_cnt[g] = any_n ? ((m_cnt[g] < mb) ? m_cnt[g] + 1 : m_cnt[g]) : 0;
        for (int j = 0; j < B; j++) begin
          word = ref_mem[g][j][a];
          if (ww[k]) begin
            for (int b = 0; b < 8; b++)
              if (wstrb[k*64 + j*8 + b]) word[b*8 +: 8] = wwdata[k*512 + j*64 + b*8 +: 8];
            ref_mem[g][j][a] = word;
          end else begin
            data[j*64 +: 64] = word;
          end
        end
        if (!ww[k]) schedule(g, 1'b1, k, 8'h00, data);
      end else begin
        e_nr = nv; e_cs = nv; e_wen = nv & nw; e_add = naddr;
        m_cnt[g] = 0;
        for (int j = 0; j < B; j++) begin
          if (nv[j]) begin
            a = naddr[j*AW +: AW];
            word = ref_mem[g][j][a];
            if (nw[j]) begin
              for (int b = 0; b < 8; b++)
                if (nstrb[j*8 + b]) word[b*8 +: 8] = nwdata[j*64 + b*8 +: 8];
              ref_mem[g][j][a] = word;
            end else begin
              mask[j] = 1'b1;
              data[j*64 +: 64] = word;
            end
          end
        end
        if (mask != 0) schedule(g, 1'b0, 0, mask, data);
      end
    end
    for (int j = 0; j < B; j++) if (e_cs[j]) add_mask[j*AW +: AW] = '1;
    check("wide_ready", g, wide_ready[g], e_wr);
    check("narrow_ready", g, narrow_ready[g], e_nr);
    check("mem_cs", g, mem_cs[g], e_cs);
    check("mem_wen", g, rst ? mem_wen[g] : (mem_wen[g] & e_cs), e_wen);
    check("mem_add", g, mem_add[g] & add_mask, e_add & add_mask);
    check("wide_rsp_valid", g, wide_rsp_valid[g], e_wrv);
    check("narrow_rsp_valid", g, narrow_rsp_valid[g], e_nrv);
    if (e_wrv != 0) check("wide_rdata", g, wide_rdata[g], e_d);
    if (e_nrv != 0) check("narrow_rdata", g, narrow_rdata[g] & d_mask, e_d);
  endtask

  task automatic tick();
    #1;
    for (int g = 0; g < NInst; g++) model_check(g);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wv = '0; ww = '0; nv = '0; nw = '0;
    waddr = '0; naddr = '0; wwdata = '0; nwdata = '0; wstrb = '1; nstrb = '1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom % 4 == 0) ? AW'($urandom % 1024) : AW'($urandom % 8);
  endfunction

  task automatic random_inputs();
    wv = W'($urandom % 4);
    ww = W'($urandom % 4);
    nw = 8'($urandom);
    case ($urandom % 3)
      0: nv = '0;
      1: nv = 8'($urandom);
      default: nv = 8'(1 << ($urandom % 8));
    endcase
    for (int i = 0; i < W; i++) waddr[i*AW +: AW] = rand_addr();
    for (int j = 0; j < B; j++) naddr[j*AW +: AW] = rand_addr();
    for (int i = 0; i < W*WDW/32; i++) wwdata[i*32 +: 32] = $urandom;
    for (int i = 0; i < B*NDW/32; i++) nwdata[i*32 +: 32] = $urandom;
    for (int i = 0; i < W*WDW/256; i++) wstrb[i*32 +: 32] = ($urandom % 2 == 0) ? '1 : $urandom;
    for (int i = 0; i < B*NDW/256; i++) nstrb[i*32 +: 32] = ($urandom % 2 == 0) ? '1 : $urandom;
  endtask

  logic [511:0] pat_a5;
  int           n1_grant, n1_rsp;
  logic [1:0]   e_w;
  logic [7:0]   e_n;

  initial begin
    for (int g = 0; g < NInst; g++) begin
      m_rr[g] = 0; m_cnt[g] = 0;
      for (int s = 0; s < 8; s++) sv[g][s] = 1'b0;
      for (int j = 0; j < B; j++)
        for (int a = 0; a < 1024; a++) ref_mem[g][j][a] = '0;
    end
    pat_a5 = {64{8'hA5}};
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;

    // Wide0 write then read of address 3
    wv = 2'b01; ww = 2'b01; waddr[0 +: AW] = 10'd3; wwdata[0 +: 512] = pat_a5;
    #1;
    check("wr_grant_cs", 0, mem_cs[0], 8'hFF);
    tick();
    ww = 2'b00; wwdata = '0;
    #1;
    check("rd_grant_cs", 0, mem_cs[0], 8'hFF);
    tick();
    check("rd_rsp_valid", 0, wide_rsp_valid[0], 2'b01);
    check("rd_rsp_data", 0, wide_rdata[0], pat_a5);

    // Read grant, reset the following cycle: the response must be dropped
    wv = 2'b01; ww = 2'b00; waddr[0 +: AW] = 10'd3;
    tick();
    rst = 1'b1; wv = 2'b00;
    tick();
    rst = 1'b0; wv = 2'b11;
    #1;
    check("dropped_rsp", 2, wide_rsp_valid[2], 2'b00);
    for (int g = 0; g < NInst; g++) check("post_reset_grant", g, wide_ready[g], 2'b01);

    // Both wide inputs valid: grants alternate
    for (int i = 0; i < 8; i++) begin
      waddr = {AW'($urandom % 8), AW'($urandom % 8)};
      #1;
      e_w = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_alternate", 0, wide_ready[0], e_w);
      tick();
    end

    // Wide0 plus narrow port 5 read: starvation guard pattern
    wv = 2'b01; ww = 2'b00; waddr = '0; nv = 8'h20; nw = 8'h00; naddr[5*AW +: AW] = 10'd3;
    n1_grant = 0; n1_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      e_n = (i % 5 == 4) ? 8'h20 : 8'h00;
      check("guard_narrow_ready", 0, narrow_ready[0], e_n);
      if (narrow_ready[1] != 0) n1_grant++;
      tick();
      check("guard_narrow_rsp", 0, narrow_rsp_valid[0], e_n);
      if (narrow_rsp_valid[1] != 0) n1_rsp++;
    end
    check("strict_wide_narrow_grants", 1, 512'(n1_grant), 512'd0);
    check("strict_wide_narrow_rsps", 1, 512'(n1_rsp), 512'd0);

    // Latency-3 tagged responses; writes in between produce nothing
    idle_inputs();
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      case (i)
        0: begin wv = 2'b10; waddr = {10'd5, 10'd0}; end
        1: begin nv = 8'h81; naddr = {10'd2, 60'd0, 10'd3}; end
        2: begin wv = 2'b01; waddr = {10'd0, 10'd3}; end
        3: begin wv = 2'b01; ww = 2'b01; waddr = {10'd0, 10'd7}; end
        4: begin nv = 8'h81; nw = 8'h81; end
        default: ;
      endcase
      tick();
      e_w = (i + 1 == 3) ? 2'b10 : ((i + 1 == 5) ? 2'b01 : 2'b00);
      e_n = (i + 1 == 4) ? 8'h81 : 8'h00;
      check("lat3_wide_rsp", 1, wide_rsp_valid[1], e_w);
      check("lat3_narrow_rsp", 1, narrow_rsp_valid[1], e_n);
    end

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      random_inputs();
      rst = ($urandom % 150 == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
